// File: rtl/vernam_stream_engine.sv
// vernam_stream_engine: XOR stream cipher shared by two PicoBlaze ports.
// Side B loads a key FIFO; side A submits plaintext and pops ciphertext from an output FIFO.
module vernam_stream_engine #(
    parameter int         DATA_W    = 8,
    parameter int         KEY_DEPTH = 16,
    parameter int         OUT_DEPTH = 16,
    parameter logic [7:0] PORT_BASE = 8'h00,
    parameter int         IRQ_LEVEL = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        a_port_id,
    input  logic [DATA_W-1:0] a_out_port,
    input  logic              a_write_strobe,
    input  logic              a_read_strobe,
    output logic [DATA_W-1:0] a_in_port,
    output logic              a_interrupt,
    input  logic [7:0]        b_port_id,
    input  logic [DATA_W-1:0] b_out_port,
    input  logic              b_write_strobe,
    output logic [DATA_W-1:0] b_in_port
);
    localparam int KAW = $clog2(KEY_DEPTH);
    localparam int KCW = $clog2(KEY_DEPTH + 1);
    localparam int OAW = $clog2(OUT_DEPTH);
    localparam int OCW = $clog2(OUT_DEPTH + 1);
    localparam logic [KCW-1:0] K_MAX = KCW'(KEY_DEPTH);
    localparam logic [OCW-1:0] O_MAX = OCW'(OUT_DEPTH);
    localparam logic [OCW-1:0] O_IRQ = OCW'(IRQ_LEVEL);
    localparam logic [7:0] P0 = PORT_BASE;
    localparam logic [7:0] P1 = PORT_BASE + 8'd1;
    localparam logic [7:0] P2 = PORT_BASE + 8'd2;
    localparam logic [7:0] P3 = PORT_BASE + 8'd3;

    logic [DATA_W-1:0] k_mem_q [KEY_DEPTH];
    logic [DATA_W-1:0] o_mem_q [OUT_DEPTH];
    logic [KAW-1:0]    k_rd_q, k_rd_d, k_wr_q, k_wr_d;
    logic [KCW-1:0]    k_cnt_q, k_cnt_d;
    logic [OAW-1:0]    o_rd_q, o_rd_d, o_wr_q, o_wr_d;
    logic [OCW-1:0]    o_cnt_q, o_cnt_d;
    logic              mode_q, mode_d, unf_q, unf_d, ovf_q, ovf_d, irq_q, irq_d;
    logic [DATA_W-1:0] a_in_q, a_in_d, b_in_q, b_in_d;

    logic pt_wr, ctrl_wr, ct_rd, b_push;
    logic k_empty, k_full, o_empty, o_full;
    logic k_flush, o_flush, clr;
    logic o_pop_raw, o_pop, o_push, k_pop, k_push, k_repush, b_ok;
    logic set_unf, set_ovf;
    logic [DATA_W-1:0] k_head, o_head, k_wdata, o_wdata, status;

    assign pt_wr   = a_write_strobe && a_port_id == P0;
    assign ctrl_wr = a_write_strobe && a_port_id == P2;
    assign ct_rd   = a_read_strobe && a_port_id == P0;
    assign b_push  = b_write_strobe && b_port_id == P0;
    assign k_empty = k_cnt_q == '0;
    assign k_full  = k_cnt_q == K_MAX;
    assign o_empty = o_cnt_q == '0;
    assign o_full  = o_cnt_q == O_MAX;
    assign k_flush = ctrl_wr && a_out_port[1];
    assign o_flush = ctrl_wr && a_out_port[2];
    assign clr     = ctrl_wr && a_out_port[3];
    assign k_head  = k_mem_q[k_rd_q];
    assign o_head  = o_mem_q[o_rd_q];

    // A full output FIFO still accepts plaintext when a pop frees a slot in the same cycle.
    assign o_pop_raw = ct_rd && !o_empty;
    assign o_pop     = o_pop_raw && !o_flush;
    assign k_pop     = pt_wr && !k_empty && (!o_full || o_pop_raw);
    assign o_push    = k_pop && !o_flush;
    assign o_wdata   = a_out_port ^ k_head;

    // Repeating mode recycles the consumed key and locks out side B so the ring stays fixed.
    assign k_repush = k_pop && mode_q;
    assign b_ok     = b_push && !mode_q && (!k_full || k_pop);
    assign k_push   = (k_repush || b_ok) && !k_flush;
    assign k_wdata  = k_repush ? k_head : b_out_port;

    assign set_unf = pt_wr && k_empty;
    assign set_ovf = (pt_wr && !k_empty && o_full && !o_pop_raw) || (b_push && !b_ok);
    assign status  = DATA_W'({mode_q, ovf_q, unf_q, k_full, k_empty, o_full, !o_empty});

    always_comb begin
        k_rd_d  = k_flush ? '0 : k_rd_q + KAW'(k_pop);
        k_wr_d  = k_flush ? '0 : k_wr_q + KAW'(k_push);
        k_cnt_d = k_flush ? '0 : k_cnt_q + KCW'(k_push) - KCW'(k_pop);
        o_rd_d  = o_flush ? '0 : o_rd_q + OAW'(o_pop);
        o_wr_d  = o_flush ? '0 : o_wr_q + OAW'(o_push);
        o_cnt_d = o_flush ? '0 : o_cnt_q + OCW'(o_push) - OCW'(o_pop);
        mode_d  = ctrl_wr ? a_out_port[0] : mode_q;
        unf_d   = (unf_q && !clr) || set_unf;
        ovf_d   = (ovf_q && !clr) || set_ovf;
        irq_d   = o_cnt_d >= O_IRQ;
        a_in_d  = a_port_id == P0 ? (o_empty ? '0 : o_head) :
                  a_port_id == P1 ? status :
                  a_port_id == P3 ? DATA_W'(k_cnt_q) : '0;
        b_in_d  = b_port_id == P1 ? status :
                  b_port_id == P3 ? DATA_W'(k_cnt_q) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_rd_q  <= '0;
            k_wr_q  <= '0;
            k_cnt_q <= '0;
            o_rd_q  <= '0;
            o_wr_q  <= '0;
            o_cnt_q <= '0;
            mode_q  <= 1'b0;
            unf_q   <= 1'b0;
            ovf_q   <= 1'b0;
            irq_q   <= 1'b0;
            a_in_q  <= '0;
            b_in_q  <= '0;
        end else begin
            k_rd_q  <= k_rd_d;
            k_wr_q  <= k_wr_d;
            k_cnt_q <= k_cnt_d;
            o_rd_q  <= o_rd_d;
            o_wr_q  <= o_wr_d;
            o_cnt_q <= o_cnt_d;
            mode_q  <= mode_d;
            unf_q   <= unf_d;
            ovf_q   <= ovf_d;
            irq_q   <= irq_d;
            a_in_q  <= a_in_d;
            b_in_q  <= b_in_d;
        end
    end

    always_ff @(posedge clk) begin
        if (k_push) k_mem_q[k_wr_q] <= k_wdata;
        if (o_push) o_mem_q[o_wr_q] <= o_wdata;
    end

    assign a_in_port   = a_in_q;
    assign b_in_port   = b_in_q;
    assign a_interrupt = irq_q;
endmodule

// File: doc/vernam_stream_engine.md
# vernam_stream_engine

Parametrised Vernam (XOR) stream engine shared by two PicoBlaze processors. The key processor (side B) loads keystream words into a key FIFO. The data processor (side A) writes plaintext and reads ciphertext back from an output FIFO. Both processors see the engine through decoded port addresses and registered `in_port` paths. The block adds buffering, flow-control status, error flags, an interrupt and a repeating-key mode.

## Interface
- `DATA_W`, 8, word width; must be ≥ 8.
- `KEY_DEPTH`, 16, key FIFO depth; power of two, 2..128.
- `OUT_DEPTH`, 16, output FIFO depth; power of two, 2..128.
- `PORT_BASE`, 8'h00, base port address, low 2 bits zero; offsets +0..+3 are decoded.
- `IRQ_LEVEL`, 1, output FIFO count at or above which `a_interrupt` asserts; 1..OUT_DEPTH.

- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `a_port_id` in 8: side A port address.
- `a_out_port` in DATA_W: side A write data.
- `a_write_strobe` in 1: side A write qualifier.
- `a_read_strobe` in 1: side A read qualifier.
- `a_in_port` out DATA_W: registered read data to side A.
- `a_interrupt` out 1: level interrupt, high while output count ≥ IRQ_LEVEL.
- `b_port_id` in 8: side B port address.
- `b_out_port` in DATA_W: side B write data.
- `b_write_strobe` in 1: side B write qualifier.
- `b_in_port` out DATA_W: registered read data to side B.

## Operation
**Side A port map**
- +0 write: submit plaintext.
- +0 read: pop ciphertext.
- +1 read: STATUS.
- +2 write: CTRL.
- +3 read: key count.
- +1 write, +3 write and all other addresses are ignored; reads of unmapped addresses return 0.

**Side B port map**
- +0 write: push key word.
- +1 read: STATUS.
- +3 read: key count.
- All other side B addresses are ignored or read 0.

**STATUS** (zero-extended to DATA_W)
- bit0: output FIFO non-empty.
- bit1: output FIFO full.
- bit2: key FIFO empty.
- bit3: key FIFO full.
- bit4: `underflow` (sticky).
- bit5: `overflow` (sticky).
- bit6: `mode`.
- bit7: 0.

**CTRL write**
- bit0: sets `mode` (0 = one-time pad, 1 = repeating key).
- bit1: flushes the key FIFO.
- bit2: flushes the output FIFO.
- bit3: clears both sticky flags.
- A flush wins over any same-cycle push or pop on that FIFO.

**Plaintext write P**
- Key FIFO empty: set `underflow`, drop P.
- Output FIFO full with no same-cycle pop: set `overflow`, drop P, consume no key.
- Otherwise: pop key K, push P^K to the output FIFO.
  - If `mode`=1, K is re-pushed to the key tail in the same cycle, so the key count is unchanged.

**Key push (side B)**
- Accepted when the key count < KEY_DEPTH, or when a side A pop occurs in the same cycle in mode 0.
- In mode 1, side B pushes are dropped and set `overflow`; this keeps the key ring fixed.
- A rejected push when full sets `overflow`.

**Ciphertext pop**
- `a_read_strobe` at +0 pops one word when the output FIFO is non-empty.
- Popping an empty FIFO is ignored, with no flag.

**Ordering and pointers**
- Both FIFOs keep strict FIFO order.
- Pointers wrap modulo depth; counts are clog2(depth+1) bits wide.

**Reset** (asynchronous, `reset_n` low)
- Both FIFOs empty.
- `mode`=0, sticky flags 0.
- `a_in_port`=0, `b_in_port`=0, `a_interrupt`=0.
- Reset can interrupt any operation; contents are discarded.

## Timing
- All state updates on the rising `clk` edge of a strobed cycle N; the effect is visible to an address presented in cycle N+1.
- `a_in_port` and `b_in_port` are registered from the `port_id` of cycle N plus state at the start of N. Data is valid in N+1, which is compatible with the two-cycle PicoBlaze INPUT instruction.
- The ciphertext word presented on `a_in_port` is the FIFO head. The pop (strobe in cycle N) advances the head at the end of N.
- Plaintext-to-ciphertext latency: written in N, readable by an INPUT issued from N+1.
- `a_interrupt` is registered and updates one cycle after the count change.
- Same-cycle push and pop on a FIFO: both take effect and the count is unchanged.
- Sticky flags set and clear in the same cycle: the set wins.

## Test plan
- Reset: after reset, push keys 8'h5A and 8'h0F from B; A writes 8'hFF then 8'h00. A then reads 8'hA5, 8'h0F, STATUS 8'h04, and underflow = 0.
- Underflow: with the key FIFO empty, A writes 8'h11 -> STATUS bit4=1 and the output stays empty. CTRL 8'h08 then clears bit4.
- Full boundaries: B pushes 17 keys (KEY_DEPTH=16) -> count 16 and `overflow`=1. Fill the output FIFO to 16, then a simultaneous A write plus pop -> accepted, count stays 16.
- Repeating mode: CTRL 8'h01 with keys {8'h01,8'h02}; A writes 8'h00 four times -> reads 01,02,01,02, key count stays 2; a B push sets `overflow`.
- Interrupt: IRQ_LEVEL=3; writing 3 plaintexts -> `a_interrupt` high one cycle after the third write, and low one cycle after the first pop.
- Async reset: assert `reset_n` low mid-stream with both FIFOs partly full -> all outputs 0 immediately, and STATUS reads 8'h04 after release.
